// File: rtl/cpu_mem_responder_pkg.sv
// Shared types and constants for the core-side memory responder.
package cpu_mem_responder_pkg;

  localparam int MASK_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_REQ  = 3'd1,
    ST_D_WAIT = 3'd2,
    ST_I_REQ  = 3'd3,
    ST_I_WAIT = 3'd4
  } state_e;

  function automatic logic is_store(input logic [MASK_W-1:0] we);
    return |we;
  endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// Core request/response and backing-memory channel bundle.
interface cpu_mem_responder_if
  import cpu_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   icache_addr;
  logic                icache_re;
  logic [DATA_W-1:0]   icache_dout;
  logic [ADDR_W-1:0]   dcache_addr;
  logic                dcache_re;
  logic [MASK_W-1:0]   dcache_we;
  logic [DATA_W-1:0]   dcache_din;
  logic [DATA_W-1:0]   dcache_dout;
  logic                stall;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_rw;
  logic [ADDR_W-3:0]   mem_req_addr;
  logic [DATA_W-1:0]   mem_req_data;
  logic [MASK_W-1:0]   mem_req_mask;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_resp_data;

  modport slave (
    input  icache_addr, icache_re, dcache_addr, dcache_re, dcache_we, dcache_din,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output icache_dout, dcache_dout, stall,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask
  );

  modport master (
    output icache_addr, icache_re, dcache_addr, dcache_re, dcache_we, dcache_din,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  icache_dout, dcache_dout, stall,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask
  );

endinterface

// File: rtl/cpu_mem_responder_fetch_reuse_buffer.sv
// One-entry fetch reuse buffer: remembers the last fetched word address and
// drops it when a store hits that word.
module fetch_reuse_buffer #(
  parameter int WA_W = 30
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WA_W-1:0] lookup_addr,
  output logic            hit,
  input  logic            fill_en,
  input  logic [WA_W-1:0] fill_addr,
  input  logic            inval_en,
  input  logic [WA_W-1:0] inval_addr
);

  logic [WA_W-1:0] reuse_addr_r;
  logic            reuse_valid_r;

  // Fill wins over invalidation; the two never coincide in practice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reuse_addr_r  <= '0;
      reuse_valid_r <= 1'b0;
    end else if (fill_en) begin
      reuse_addr_r  <= fill_addr;
      reuse_valid_r <= 1'b1;
    end else if (inval_en && (inval_addr == reuse_addr_r)) begin
      reuse_valid_r <= 1'b0;
    end
  end

  assign hit = reuse_valid_r && (lookup_addr == reuse_addr_r);

endmodule

// File: rtl/cpu_mem_responder.sv
// Services core icache/dcache requests over a single backing-memory channel,
// data access first, stalling the core while a service is in flight.
module cpu_mem_responder
  import cpu_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  cpu_mem_responder_if.slave  bus
);

  localparam int WA_W = ADDR_W - 2;

  state_e              state_r, state_s;
  logic                pend_i_r, pend_d_r, pend_d_re_r;
  logic [WA_W-1:0]     pend_i_addr_r, pend_d_addr_r;
  logic [MASK_W-1:0]   pend_d_we_r;
  logic [DATA_W-1:0]   pend_d_din_r;
  logic [DATA_W-1:0]   icache_dout_r, dcache_dout_r;

  logic                stall_s, accept_s, in_dacc_s;
  logic [WA_W-1:0]     in_i_addr_s, in_d_addr_s, lookup_addr_s;
  logic                hit_s, store_inv_s;
  logic                clr_i_s, clr_d_s, load_i_s, load_d_s, fill_s;
  logic                req_valid_s, req_rw_s;
  logic [WA_W-1:0]     req_addr_s;
  logic [DATA_W-1:0]   req_data_s;
  logic [MASK_W-1:0]   req_mask_s;
  logic                unused_s;

  assign in_i_addr_s = bus.icache_addr[ADDR_W-1:2];
  assign in_d_addr_s = bus.dcache_addr[WA_W-1:0];
  assign unused_s    = ^{bus.icache_addr[1:0], bus.dcache_addr[ADDR_W-1:WA_W]};
  assign in_dacc_s   = bus.dcache_re || is_store(bus.dcache_we);

  assign stall_s     = (state_r != ST_IDLE) || pend_d_r || pend_i_r;
  assign accept_s    = !stall_s;
  // In IDLE the fetch is judged on the live request, afterwards on the captured one.
  assign lookup_addr_s = (state_r == ST_IDLE) ? in_i_addr_s : pend_i_addr_r;
  assign store_inv_s   = accept_s && is_store(bus.dcache_we);

  fetch_reuse_buffer #(.WA_W(WA_W)) u_reuse (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (lookup_addr_s),
    .hit         (hit_s),
    .fill_en     (fill_s),
    .fill_addr   (pend_i_addr_r),
    .inval_en    (store_inv_s),
    .inval_addr  (in_d_addr_s)
  );

  // Request capture; a lone reuse hit never becomes pending so it costs no stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_i_r      <= 1'b0;
      pend_d_r      <= 1'b0;
      pend_d_re_r   <= 1'b0;
      pend_i_addr_r <= '0;
      pend_d_addr_r <= '0;
      pend_d_we_r   <= '0;
      pend_d_din_r  <= '0;
    end else if (accept_s) begin
      pend_i_r      <= bus.icache_re && (in_dacc_s || !hit_s);
      pend_d_r      <= in_dacc_s;
      pend_d_re_r   <= bus.dcache_re;
      pend_i_addr_r <= in_i_addr_s;
      pend_d_addr_r <= in_d_addr_s;
      pend_d_we_r   <= bus.dcache_we;
      pend_d_din_r  <= bus.dcache_din;
    end else begin
      if (clr_i_s) pend_i_r <= 1'b0;
      if (clr_d_s) pend_d_r <= 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Next state and backing-memory request drive.
  always_comb begin
    state_s     = state_r;
    clr_i_s     = 1'b0;
    clr_d_s     = 1'b0;
    load_i_s    = 1'b0;
    load_d_s    = 1'b0;
    fill_s      = 1'b0;
    req_valid_s = 1'b0;
    req_rw_s    = 1'b0;
    req_addr_s  = pend_i_addr_r;
    req_data_s  = pend_d_din_r;
    req_mask_s  = '0;
    case (state_r)
      ST_IDLE: begin
        if (in_dacc_s)                     state_s = ST_D_REQ;
        else if (bus.icache_re && !hit_s)  state_s = ST_I_REQ;
        else                               state_s = ST_IDLE;
      end
      ST_D_REQ: begin
        req_valid_s = 1'b1;
        req_rw_s    = is_store(pend_d_we_r);
        req_addr_s  = pend_d_addr_r;
        req_mask_s  = pend_d_we_r;
        if (bus.mem_req_ready) state_s = ST_D_WAIT;
        else                   state_s = ST_D_REQ;
      end
      ST_D_WAIT: begin
        if (bus.mem_resp_valid) begin
          clr_d_s  = 1'b1;
          load_d_s = pend_d_re_r && !is_store(pend_d_we_r);
          if (pend_i_r && !hit_s) begin
            state_s = ST_I_REQ;
          end else begin
            clr_i_s = 1'b1;
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_D_WAIT;
        end
      end
      ST_I_REQ: begin
        req_valid_s = 1'b1;
        if (bus.mem_req_ready) state_s = ST_I_WAIT;
        else                   state_s = ST_I_REQ;
      end
      ST_I_WAIT: begin
        if (bus.mem_resp_valid) begin
          load_i_s = 1'b1;
          fill_s   = 1'b1;
          clr_i_s  = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          state_s = ST_I_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Read data registers; they only move while the core is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      icache_dout_r <= '0;
      dcache_dout_r <= '0;
    end else begin
      if (load_i_s) icache_dout_r <= bus.mem_resp_data;
      if (load_d_s) dcache_dout_r <= bus.mem_resp_data;
    end
  end

  assign bus.icache_dout   = icache_dout_r;
  assign bus.dcache_dout   = dcache_dout_r;
  assign bus.stall         = stall_s;
  assign bus.mem_req_valid = req_valid_s;
  assign bus.mem_req_rw    = req_rw_s;
  assign bus.mem_req_addr  = req_addr_s;
  assign bus.mem_req_data  = req_data_s;
  assign bus.mem_req_mask  = req_mask_s;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: directed core traffic, a small
// backing-memory model, and a monitor checking requests and read data.
module tb_cpu_mem_responder;

  typedef struct {
    logic        rw;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_t;

  typedef struct {
    logic [31:0] idout;
    logic [31:0] ddout;
    int          stall_len;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  logic spurious;
  logic [31:0] mem [0:255];
  req_t exp_req_q[$];
  out_t exp_out_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cpu_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cpu_mem_responder #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_req(input logic rw, input logic [29:0] addr, input logic [31:0] data,
                          input logic [3:0] mask);
    req_t r;
    r.rw = rw; r.addr = addr; r.data = data; r.mask = mask;
    exp_req_q.push_back(r);
  endtask

  task automatic push_out(input logic [31:0] idout, input logic [31:0] ddout, input int len);
    out_t o;
    o.idout = idout; o.ddout = ddout; o.stall_len = len;
    exp_out_q.push_back(o);
  endtask

  // Backing memory: accepts at the negedge sample, answers one cycle later.
  initial begin
    logic        fire;
    logic [31:0] rdata;
    logic [31:0] w;
    fire = 1'b0;
    rdata = 32'h0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        fire = 1'b0;
      end else begin
        fire = bus.mem_req_valid && bus.mem_req_ready;
        if (fire) begin
          w = mem[bus.mem_req_addr[7:0]];
          if (bus.mem_req_rw) begin
            for (int b = 0; b < 4; b++)
              if (bus.mem_req_mask[b]) w[b*8 +: 8] = bus.mem_req_data[b*8 +: 8];
            mem[bus.mem_req_addr[7:0]] = w;
          end else begin
            rdata = w;
          end
        end
      end
      @(posedge clk);
      #1;
      bus.mem_resp_valid = fire || spurious;
      bus.mem_resp_data  = spurious ? 32'hDEAD_BEEF : rdata;
    end
  end

  // Monitor: compares every presented request and the douts at each stall fall.
  initial begin
    int   run;
    req_t r;
    out_t o;
    run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0;
      end else begin
        if (bus.mem_req_valid) begin
          if (exp_req_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_req: got addr %h rw %b, expected none", bus.mem_req_addr, bus.mem_req_rw);
          end else begin
            r = exp_req_q[0];
            check32("req_rw", {31'd0, bus.mem_req_rw}, {31'd0, r.rw});
            check32("req_addr", {2'd0, bus.mem_req_addr}, {2'd0, r.addr});
            if (r.rw) begin
              check32("req_data", bus.mem_req_data, r.data);
              check32("req_mask", {28'd0, bus.mem_req_mask}, {28'd0, r.mask});
            end
            if (bus.mem_req_ready) void'(exp_req_q.pop_front());
          end
        end
        if (bus.stall) begin
          run++;
        end else if (run > 0) begin
          if (exp_out_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_service: got stall run %0d, expected none", run);
          end else begin
            o = exp_out_q.pop_front();
            check32("icache_dout", bus.icache_dout, o.idout);
            check32("dcache_dout", bus.dcache_dout, o.ddout);
            check32("stall_len", run, o.stall_len);
          end
          run = 0;
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.icache_re   = 1'b0;
    bus.icache_addr = 32'h0;
    bus.dcache_re   = 1'b0;
    bus.dcache_we   = 4'b0000;
    bus.dcache_addr = 32'h0;
    bus.dcache_din  = 32'h0;
  endtask

  task automatic issue(input logic ire, input logic [31:0] iaddr, input logic dre,
                       input logic [3:0] we, input logic [31:0] daddr, input logic [31:0] din);
    bus.icache_re   = ire;
    bus.icache_addr = iaddr;
    bus.dcache_re   = dre;
    bus.dcache_we   = we;
    bus.dcache_addr = daddr;
    bus.dcache_din  = din;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!bus.stall) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: got stall still high after %0d cycles, expected idle", budget);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h0050_0093;
    mem[8'h41] = 32'h00A0_0113;
    mem[8'h80] = 32'h1234_5678;
    mem[8'h90] = 32'hCAFE_F00D;
    spurious = 1'b0;
    reset = 1'b1;
    bus.mem_req_ready = 1'b1;
    idle_inputs();

    // Power-up reset state.
    @(negedge clk);
    check32("rst_stall", {31'd0, bus.stall}, 32'd0);
    check32("rst_icache_dout", bus.icache_dout, 32'd0);
    check32("rst_dcache_dout", bus.dcache_dout, 32'd0);
    check32("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    @(posedge clk); #2; reset = 1'b0;
    @(posedge clk); #1;

    // Fetch miss, minimum latency.
    push_req(1'b0, 30'h40, 32'h0, 4'b0000);
    push_out(32'h0050_0093, 32'h0, 2);
    issue(1'b1, 32'h100, 1'b0, 4'b0000, 32'h0, 32'h0);
    wait_idle(20);

    // Repeat fetch: reuse hit, no backing access, no stall.
    issue(1'b1, 32'h100, 1'b0, 4'b0000, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("hit_stall", {31'd0, bus.stall}, 32'd0);
      check32("hit_icache_dout", bus.icache_dout, 32'h0050_0093);
    end
    @(posedge clk); #1;

    // Partial store to the reused word plus same fetch: write then refetch.
    push_req(1'b1, 30'h40, 32'h0000_BEEF, 4'b0011);
    push_req(1'b0, 30'h40, 32'h0, 4'b0000);
    push_out(32'h0050_BEEF, 32'h0, 4);
    issue(1'b1, 32'h100, 1'b0, 4'b0011, 32'h40, 32'h0000_BEEF);
    wait_idle(30);

    // Load and fetch together under backpressure.
    push_req(1'b0, 30'h80, 32'h0, 4'b0000);
    push_req(1'b0, 30'h41, 32'h0, 4'b0000);
    push_out(32'h00A0_0113, 32'h1234_5678, 7);
    bus.mem_req_ready = 1'b0;
    issue(1'b1, 32'h104, 1'b1, 4'b0000, 32'h80, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b1;
    wait_idle(30);

    // Spurious response while idle must be ignored.
    @(posedge clk); #3; spurious = 1'b1;
    @(posedge clk); #3; spurious = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("spur_stall", {31'd0, bus.stall}, 32'd0);
      check32("spur_icache_dout", bus.icache_dout, 32'h00A0_0113);
      check32("spur_dcache_dout", bus.dcache_dout, 32'h1234_5678);
    end
    @(posedge clk); #1;

    // Reset in the middle of a load's response wait.
    push_req(1'b0, 30'h90, 32'h0, 4'b0000);
    issue(1'b0, 32'h0, 1'b1, 4'b0000, 32'h90, 32'h0);
    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;
    @(negedge clk);
    check32("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
    check32("mid_rst_icache_dout", bus.icache_dout, 32'd0);
    check32("mid_rst_dcache_dout", bus.dcache_dout, 32'd0);
    check32("mid_rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    @(posedge clk); #1;

    // Reuse entry was cleared by reset, so this fetch goes to memory.
    push_req(1'b0, 30'h41, 32'h0, 4'b0000);
    push_out(32'h00A0_0113, 32'h0, 2);
    issue(1'b1, 32'h104, 1'b0, 4'b0000, 32'h0, 32'h0);
    wait_idle(20);

    @(negedge clk);
    check32("req_queue_empty", exp_req_q.size(), 32'd0);
    check32("out_queue_empty", exp_out_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
